qa_shim_rd_throttle: RTL and testbench

// - Composable QA driver shim between the QLP and the AFU. It sits directly on the AFU side of a qlp_interface.
// - Buffers AFU channel-0 read requests in a small FIFO and caps the number of in-flight reads at the QLP.
// - Generates C0TxAlmFull toward the AFU from its own FIFO occupancy.
// - All other channel-0 and channel-1 traffic passes straight through.
//

---
 rtl/qa_driver_types.sv | 23 ++
 rtl/qlp_interface.sv | 59 +++++
 rtl/qa_shim_fifo.sv | 66 ++++++
 rtl/qa_shim_rd_throttle.sv | 130 +++++++++++++
 tb/tb_qa_shim_rd_throttle.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qa_driver_types.sv
// ============================================================================
// Module : qa_driver_types
// Brief  : Shared CCI widths and header types for the QA driver shims.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package qa_driver_types;

    localparam int CCI_TX_HDR_WIDTH = 61;
    localparam int CCI_RX_HDR_WIDTH = 18;
    localparam int CCI_DATA_WIDTH   = 512;

    localparam int QA_SHIM_RD_MAX_OUTSTANDING_DEFAULT = 64;

    typedef logic [CCI_TX_HDR_WIDTH-1:0] t_cci_c0_req_hdr;
    typedef logic [CCI_TX_HDR_WIDTH-1:0] t_cci_c1_req_hdr;
    typedef logic [CCI_RX_HDR_WIDTH-1:0] t_cci_rsp_hdr;
    typedef logic [CCI_DATA_WIDTH-1:0]   t_cci_data;

endpackage

`default_nettype wire

// File: rtl/qlp_interface.sv
// ============================================================================
// Module : qlp_interface
// Brief  : QLP <-> AFU channel bundle; to_qlp faces the platform, to_afu the user.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface qlp_interface;
    import qa_driver_types::*;

    logic            resetb;

    t_cci_c0_req_hdr C0TxHdr;
    logic            C0TxRdValid;
    logic            C0TxAlmFull;

    t_cci_c1_req_hdr C1TxHdr;
    t_cci_data       C1TxData;
    logic            C1TxWrValid;
    logic            C1TxIrValid;
    logic            C1TxAlmFull;

    t_cci_rsp_hdr    C0RxHdr;
    t_cci_data       C0RxData;
    logic            C0RxWrValid;
    logic            C0RxRdValid;
    logic            C0RxCgValid;
    logic            C0RxUgValid;
    logic            C0RxIrValid;

    t_cci_rsp_hdr    C1RxHdr;
    logic            C1RxWrValid;
    logic            C1RxIrValid;

    modport to_qlp (
        input  resetb,
        output C0TxHdr, C0TxRdValid,
        input  C0TxAlmFull,
        output C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
        input  C1TxAlmFull,
        input  C0RxHdr, C0RxData, C0RxWrValid, C0RxRdValid,
        input  C0RxCgValid, C0RxUgValid, C0RxIrValid,
        input  C1RxHdr, C1RxWrValid, C1RxIrValid
    );

    modport to_afu (
        output resetb,
        input  C0TxHdr, C0TxRdValid,
        output C0TxAlmFull,
        input  C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
        output C1TxAlmFull,
        output C0RxHdr, C0RxData, C0RxWrValid, C0RxRdValid,
        output C0RxCgValid, C0RxUgValid, C0RxIrValid,
        output C1RxHdr, C1RxWrValid, C1RxIrValid
    );

endinterface

`default_nettype wire

// File: rtl/qa_shim_fifo.sv
// ============================================================================
// Module : qa_shim_fifo
// Brief  : Generic synchronous FIFO, registered count, read-first on enq+deq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qa_shim_fifo #(
    parameter int WIDTH = 61,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     enq_en,
    input  logic [WIDTH-1:0]         enq_data,
    input  logic                     deq_en,
    output logic [WIDTH-1:0]         first,
    output logic                     notEmpty,
    output logic                     notFull,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_enq, do_deq;

    always_comb begin
        do_deq   = deq_en && (count_q != '0);
        do_enq   = enq_en && ((count_q != CW'(DEPTH)) || do_deq);
        wr_ptr_d = do_enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_enq) - CW'(do_deq);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr_q] <= enq_data;
        end
    end

    assign first    = mem[rd_ptr_q];
    assign notEmpty = (count_q != '0);
    assign notFull  = (count_q != CW'(DEPTH));
    assign count    = count_q;

endmodule

`default_nettype wire

// File: rtl/qa_shim_rd_throttle.sv
// ============================================================================
// Module : qa_shim_rd_throttle
// Brief  : Buffers AFU C0 reads and caps reads in flight at the QLP.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qa_shim_rd_throttle #(
    parameter int CCI_TX_HDR_WIDTH = qa_driver_types::CCI_TX_HDR_WIDTH,
    parameter int FIFO_DEPTH       = 16,
    parameter int ALMFULL_SLACK    = 4,
    parameter int MAX_OUTSTANDING  = qa_driver_types::QA_SHIM_RD_MAX_OUTSTANDING_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 resetb,
    qlp_interface.to_qlp                         qlp,
    qlp_interface.to_afu                         afu,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 error
);
    import qa_driver_types::*;

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] ALMFULL_LEVEL = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);
    localparam logic [OUT_W-1:0] OUT_MAX       = OUT_W'(MAX_OUTSTANDING);

    logic [CCI_TX_HDR_WIDTH-1:0] fifo_first;
    logic                        fifo_not_empty, fifo_not_full;
    logic [CNT_W-1:0]            fifo_count, count_next;
    logic                        issue, bypass, pop, enq, drop, underflow;

    logic                        rd_valid_q, rd_valid_d;
    logic [CCI_TX_HDR_WIDTH-1:0] rd_hdr_q, rd_hdr_d;
    logic                        almfull_q, almfull_d;
    logic [OUT_W-1:0]            out_q, out_d;
    logic [OUT_W-1:0]            grace_q, grace_d;
    logic                        error_q, error_d;

    qa_shim_fifo #(
        .WIDTH (CCI_TX_HDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetb   (resetb),
        .enq_en   (enq),
        .enq_data (afu.C0TxHdr),
        .deq_en   (pop),
        .first    (fifo_first),
        .notEmpty (fifo_not_empty),
        .notFull  (fifo_not_full),
        .count    (fifo_count)
    );

    always_comb begin
        issue      = (fifo_not_empty || afu.C0TxRdValid) && !qlp.C0TxAlmFull && (out_q < OUT_MAX);
        // An empty FIFO lets the incoming request go straight to the output register.
        bypass     = issue && !fifo_not_empty;
        pop        = issue && fifo_not_empty;
        enq        = afu.C0TxRdValid && !bypass && (fifo_not_full || pop);
        drop       = afu.C0TxRdValid && !fifo_not_full && !pop;
        underflow  = qlp.C0RxRdValid && (out_q == '0) && !issue;
        count_next = fifo_count + CNT_W'(enq) - CNT_W'(pop);

        rd_valid_d = issue;
        rd_hdr_d   = rd_hdr_q;
        if (issue) begin
            rd_hdr_d = fifo_not_empty ? fifo_first : afu.C0TxHdr;
        end
        almfull_d  = (count_next >= ALMFULL_LEVEL);

        out_d = out_q;
        if (issue && !qlp.C0RxRdValid) begin
            out_d = out_q + OUT_W'(1);
        end else if (!issue && qlp.C0RxRdValid && (out_q != '0)) begin
            out_d = out_q - OUT_W'(1);
        end

        // Responses to reads lost across a reset are tolerated until the window closes.
        grace_d = grace_q;
        if (qlp.C0RxRdValid && (grace_q != OUT_MAX)) begin
            grace_d = grace_q + OUT_W'(1);
        end
        error_d = error_q || drop || (underflow && (grace_q == OUT_MAX));
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_valid_q <= 1'b0;
            rd_hdr_q   <= '0;
            almfull_q  <= 1'b1;
            out_q      <= '0;
            grace_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_hdr_q   <= rd_hdr_d;
            almfull_q  <= almfull_d;
            out_q      <= out_d;
            grace_q    <= grace_d;
            error_q    <= error_d;
        end
    end

    assign qlp.C0TxRdValid = rd_valid_q;
    assign qlp.C0TxHdr     = rd_hdr_q;
    assign afu.C0TxAlmFull = almfull_q;
    assign outstanding     = out_q;
    assign error           = error_q;

    assign afu.resetb      = qlp.resetb;
    assign qlp.C1TxHdr     = afu.C1TxHdr;
    assign qlp.C1TxData    = afu.C1TxData;
    assign qlp.C1TxWrValid = afu.C1TxWrValid;
    assign qlp.C1TxIrValid = afu.C1TxIrValid;
    assign afu.C1TxAlmFull = qlp.C1TxAlmFull;
    assign afu.C0RxHdr     = qlp.C0RxHdr;
    assign afu.C0RxData    = qlp.C0RxData;
    assign afu.C0RxWrValid = qlp.C0RxWrValid;
    assign afu.C0RxRdValid = qlp.C0RxRdValid;
    assign afu.C0RxCgValid = qlp.C0RxCgValid;
    assign afu.C0RxUgValid = qlp.C0RxUgValid;
    assign afu.C0RxIrValid = qlp.C0RxIrValid;
    assign afu.C1RxHdr     = qlp.C1RxHdr;
    assign afu.C1RxWrValid = qlp.C1RxWrValid;
    assign afu.C1RxIrValid = qlp.C1RxIrValid;

endmodule

`default_nettype wire

// File: tb/tb_qa_shim_rd_throttle.sv
// ============================================================================
// Module : tb_qa_shim_rd_throttle
// Brief  : Randomised bench for qa_shim_rd_throttle against a queue-based model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_qa_shim_rd_throttle;
    import qa_driver_types::*;

    localparam int FIFO_DEPTH      = 16;
    localparam int ALMFULL_SLACK   = 4;
    localparam int MAX_OUTSTANDING = 4;

    logic       clk;
    logic       resetb;
    logic [2:0] outstanding;
    logic       error;

    qlp_interface qlp_if ();
    qlp_interface afu_if ();

    assign qlp_if.resetb = resetb;

    qa_shim_rd_throttle #(
        .CCI_TX_HDR_WIDTH (CCI_TX_HDR_WIDTH),
        .FIFO_DEPTH       (FIFO_DEPTH),
        .ALMFULL_SLACK    (ALMFULL_SLACK),
        .MAX_OUTSTANDING  (MAX_OUTSTANDING)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .qlp         (qlp_if),
        .afu         (afu_if),
        .outstanding (outstanding),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending headers plus in-flight counters.
    t_cci_c0_req_hdr mq[$];
    int              m_out;
    int              m_seen;
    bit              m_err, m_valid, m_alm;
    t_cci_c0_req_hdr m_hdr;

    task automatic model_reset();
        mq.delete();
        m_out = 0; m_seen = 0; m_err = 0; m_valid = 0; m_alm = 1;
    endtask

    task automatic model_step();
        bit push, qalm, rsp, issue, consumed;
        push  = afu_if.C0TxRdValid;
        qalm  = qlp_if.C0TxAlmFull;
        rsp   = qlp_if.C0RxRdValid;
        issue = (mq.size() > 0 || push) && !qalm && (m_out < MAX_OUTSTANDING);
        consumed = 0;
        m_valid  = issue;
        if (issue) begin
            if (mq.size() > 0) begin
                m_hdr = mq.pop_front();
            end else begin
                m_hdr = afu_if.C0TxHdr;
                consumed = 1;
            end
        end
        if (push && !consumed) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back(afu_if.C0TxHdr);
            else m_err = 1;
        end
        if (rsp && m_out == 0 && !issue && m_seen >= MAX_OUTSTANDING) m_err = 1;
        if (issue) m_out++;
        if (rsp && (m_out > 0)) m_out--;
        if (rsp && m_seen < MAX_OUTSTANDING) m_seen++;
        m_alm = (mq.size() >= FIFO_DEPTH - ALMFULL_SLACK);
    endtask

    function automatic t_cci_c0_req_hdr rnd_hdr();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[CCI_TX_HDR_WIDTH-1:0];
    endfunction

    function automatic t_cci_data rnd_data();
        t_cci_data v;
        for (int i = 0; i < CCI_DATA_WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Sets the C0 read controls, randomises all pass-through traffic and checks it.
    task automatic drive(input bit push, input t_cci_c0_req_hdr hdr, input bit qalm, input bit rsp);
        t_cci_c1_req_hdr h1;
        t_cci_data       d1, d0;
        t_cci_rsp_hdr    rh0, rh1;
        logic [8:0]      r;
        h1 = rnd_hdr(); d1 = rnd_data(); d0 = rnd_data();
        rh0 = t_cci_rsp_hdr'($urandom()); rh1 = t_cci_rsp_hdr'($urandom());
        r = 9'($urandom());
        afu_if.C0TxRdValid = push;
        afu_if.C0TxHdr     = hdr;
        qlp_if.C0TxAlmFull = qalm;
        qlp_if.C0RxRdValid = rsp;
        afu_if.C1TxHdr = h1; afu_if.C1TxData = d1;
        afu_if.C1TxWrValid = r[0]; afu_if.C1TxIrValid = r[1];
        qlp_if.C1TxAlmFull = r[2];
        qlp_if.C0RxHdr = rh0; qlp_if.C0RxData = d0;
        qlp_if.C0RxWrValid = r[3]; qlp_if.C0RxCgValid = r[4];
        qlp_if.C0RxUgValid = r[5]; qlp_if.C0RxIrValid = r[6];
        qlp_if.C1RxHdr = rh1; qlp_if.C1RxWrValid = r[7]; qlp_if.C1RxIrValid = r[8];
        #1;
        check_eq("c1tx_hdr", 64'(qlp_if.C1TxHdr), 64'(h1));
        check_eq("c1tx_data", 64'(qlp_if.C1TxData == d1), 64'(1));
        check_eq("c1tx_vld", 64'({qlp_if.C1TxWrValid, qlp_if.C1TxIrValid}), 64'({r[0], r[1]}));
        check_eq("c1tx_almf", 64'(afu_if.C1TxAlmFull), 64'(r[2]));
        check_eq("c0rx_hdr", 64'(afu_if.C0RxHdr), 64'(rh0));
        check_eq("c0rx_data", 64'(afu_if.C0RxData == d0), 64'(1));
        check_eq("c0rx_vld", 64'({afu_if.C0RxWrValid, afu_if.C0RxRdValid, afu_if.C0RxCgValid,
                                  afu_if.C0RxUgValid, afu_if.C0RxIrValid}),
                 64'({r[3], rsp, r[4], r[5], r[6]}));
        check_eq("c1rx", 64'({afu_if.C1RxHdr, afu_if.C1RxWrValid, afu_if.C1RxIrValid}),
                 64'({rh1, r[7], r[8]}));
        check_eq("afu_resetb", 64'(afu_if.resetb), 64'(resetb));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("rd_valid", 64'(qlp_if.C0TxRdValid), 64'(m_valid));
        if (m_valid) check_eq("rd_hdr", 64'(qlp_if.C0TxHdr), 64'(m_hdr));
        check_eq("afu_almf", 64'(afu_if.C0TxAlmFull), 64'(m_alm));
        check_eq("outstanding", 64'(outstanding), 64'(m_out));
        check_eq("error", 64'(error), 64'(m_err));
        check_eq("fifo_count", 64'(dut.fifo_count), 64'(mq.size()));
    endtask

    task automatic check_reset_state();
        check_eq("rst_rd_valid", 64'(qlp_if.C0TxRdValid), 64'(0));
        check_eq("rst_rd_hdr", 64'(qlp_if.C0TxHdr), 64'(0));
        check_eq("rst_afu_almf", 64'(afu_if.C0TxAlmFull), 64'(1));
        check_eq("rst_afu_resetb", 64'(afu_if.resetb), 64'(0));
        check_eq("rst_outstanding", 64'(outstanding), 64'(0));
        check_eq("rst_error", 64'(error), 64'(0));
        check_eq("rst_fifo_count", 64'(dut.fifo_count), 64'(0));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (mq.size() > 0 || m_out > 0); i++) begin
            drive(0, '0, 0, m_out > 0);
            tick();
        end
    endtask

    initial begin
        resetb = 1'b0;
        model_reset();
        drive(0, '0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        resetb = 1'b1;

        // Single read: one-cycle fall-through, then its response retires it.
        drive(1, CCI_TX_HDR_WIDTH'(12'h0AB), 0, 0); tick();
        drive(0, '0, 0, 0); tick();
        drive(0, '0, 0, 1); tick();
        drive(0, '0, 0, 0); tick();

        // Burst of 17 against a blocked QLP, then release with a response each cycle.
        for (int i = 0; i < 17; i++) begin
            drive(1, rnd_hdr(), 1, 0); tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(0, '0, 0, 1); tick();
        end
        drain();

        // In-flight cap with responses withheld, then one response frees one slot.
        for (int i = 0; i < 6; i++) begin
            drive(1, rnd_hdr(), 0, 0); tick();
        end
        drive(0, '0, 0, 0); tick();
        drive(0, '0, 0, 0); tick();
        drive(0, '0, 0, 1); tick();
        drive(0, '0, 0, 0); tick();
        drive(0, '0, 0, 0); tick();
        drain();

        // Issue and response in the same cycle at three in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, rnd_hdr(), 0, 0); tick();
        end
        drive(1, rnd_hdr(), 0, 1); tick();
        drain();

        // Reset mid-operation with reads queued and in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, rnd_hdr(), 0, 0); tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, rnd_hdr(), 1, 0); tick();
        end
        resetb = 1'b0;
        #1;
        check_reset_state();
        drive(1, rnd_hdr(), 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        resetb = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 0, 0); tick();
        end
        // Stale responses: tolerated inside the post-reset window, flagged after it.
        for (int i = 0; i < MAX_OUTSTANDING + 1; i++) begin
            drive(0, '0, 0, 1); tick();
        end

        // Randomised traffic, restarted from a clean reset.
        resetb = 1'b0;
        drive(0, '0, 0, 0);
        @(posedge clk);
        #1;
        resetb = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 60, rnd_hdr(), $urandom_range(0, 99) < 25,
                  (m_out > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
